// File: rtl/scan_pkg.sv
// Shared types for the framed channel scanner: FSM states and index-width helper.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Index must hold 0 (start slot) through n (last channel).
    function automatic int idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the slow pacing signal into the clk_in domain and turns its edges into 1-cycle events.
module tick_edge_sync #(
    parameter bit TICK_BOTH = 1'b1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic time_tick,
    output logic tick_ev
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= time_tick;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick_ev = TICK_BOTH ? (s2 ^ s3) : (s2 & ~s3);

endmodule

// File: rtl/scan_select.sv
// Tick-paced framed scanner: snapshots all channels at frame start and presents
// a start slot followed by channels 1..N_CH over a valid/ready handshake.
module scan_select
    import scan_pkg::*;
#(
    parameter  int N_CH      = 16,
    parameter  int DATA_W    = 1,
    parameter  bit TICK_BOTH = 1'b1,
    localparam int IDX_W     = idx_w(N_CH)
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [N_CH*DATA_W-1:0] in,
    input  logic                   time_tick,
    input  logic                   mode_cont,
    input  logic                   trig,
    input  logic                   ovr_clr,
    output logic [DATA_W-1:0]      out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH);

    state_t                   state;
    logic                     armed;
    logic [N_CH*DATA_W-1:0]   snapshot;
    logic                     tick_ev;
    logic                     xfer;
    logic                     at_last;
    logic                     step_ok;
    logic                     frame_go;

    tick_edge_sync #(
        .TICK_BOTH(TICK_BOTH)
    ) u_tick (
        .clk_in   (clk_in),
        .reset    (reset),
        .time_tick(time_tick),
        .tick_ev  (tick_ev)
    );

    function automatic logic [DATA_W-1:0] chan(input logic [N_CH*DATA_W-1:0] snap,
                                               input logic [IDX_W-1:0] k);
        logic [N_CH*DATA_W-1:0] sh;
        sh = snap >> (DATA_W * (int'(k) - 1));
        return sh[DATA_W-1:0];
    endfunction

    assign xfer    = out_valid & out_ready;
    assign at_last = (out_idx == LAST);
    // A tick that coincides with acceptance advances just as it would from HOLD.
    assign step_ok = tick_ev && ((state == HOLD) || (state == SLOT && xfer));
    assign frame_go = (tick_ev && state == IDLE && (mode_cont || armed || trig))
                    || (step_ok && at_last && mode_cont);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            snapshot  <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_start <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A fresh overrun wins over a simultaneous clear.
            if (ovr_clr) overrun <= 1'b0;
            if (state == SLOT && tick_ev && !xfer) overrun <= 1'b1;

            if (frame_go) begin
                snapshot  <= in;
                out_idx   <= '0;
                out_data  <= '0;
                out_start <= 1'b1;
                out_valid <= 1'b1;
                armed     <= 1'b0;
                busy      <= 1'b1;
                state     <= SLOT;
            end else if (step_ok && !at_last) begin
                out_idx   <= out_idx + IDX_W'(1);
                out_data  <= chan(snapshot, out_idx + IDX_W'(1));
                out_start <= 1'b0;
                out_valid <= 1'b1;
                state     <= SLOT;
            end else if (step_ok) begin
                out_idx   <= '0;
                out_data  <= '0;
                out_start <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: if (trig) armed <= 1'b1;
                    SLOT: if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= HOLD;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
